// File: rtl/psum_collector.sv
// psum_collector
//   Accumulates adder-tree result beats across input-channel passes. On the
//   final pass of an output word it rounds and right-shifts each lane, then
//   saturates it to OW bits. The finished word goes into a 2-entry output FIFO
//   that is drained through a valid/ready handshake.
//
// Optional feature (compile-time macro PSUM_COLLECTOR_RELU_EN):
//   defined   -> negative lanes are forced to 0 after rounding/saturation
//   undefined -> lanes pass through signed
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   cfg_load        latch cfg_npass/cfg_shift, clear accumulators and pass count
//   cfg_npass       passes per output word minus 1
//   cfg_shift       arithmetic right shift applied before saturation
//   res_valid, res  adder-tree beat, NRES signed lanes of RW bits
//   stall           upstream must hold off res_valid while high (FIFO full)
//   out_valid, out_ready, out_data   output word handshake (FIFO head)
//   ovf_err         sticky: a beat arrived while the FIFO was full and was dropped
//   pass_idx        current pass count (debug)
module psum_collector #(
  parameter int NRES = 4,
  parameter int RW   = 20,
  parameter int AW   = 28,
  parameter int OW   = 16,
  parameter int SHW  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [3:0]           cfg_npass,
  input  logic [SHW-1:0]       cfg_shift,
  input  logic                 res_valid,
  input  logic [NRES*RW-1:0]   res,
  output logic                 stall,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NRES*OW-1:0]   out_data,
  output logic                 ovf_err,
  output logic [3:0]           pass_idx
);

  localparam int WW = NRES * OW;
  localparam logic signed [AW:0] SAT_MAX = {{(AW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = ~SAT_MAX;

  logic [3:0]            npass_q, npass_d;
  logic [3:0]            pass_q, pass_d;
  logic [SHW-1:0]        shift_q, shift_d;
  logic signed [AW-1:0]  acc_q [NRES];
  logic signed [AW-1:0]  acc_d [NRES];
  logic signed [AW-1:0]  sum   [NRES];
  logic [WW-1:0]         fifo_q [2];
  logic [WW-1:0]         fifo_d [2];
  logic [1:0]            cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;

  logic                  accept;
  logic                  final_beat;
  logic                  push;
  logic                  pop;
  logic signed [AW:0]    rnd;
  logic [WW-1:0]         word;

  // Half-LSB rounding constant for the current shift amount.
  always_comb begin
    rnd = '0;
    if (shift_q != '0) rnd = (AW + 1)'(1) << (shift_q - SHW'(1));
  end

  // Per-lane running sum, then round/shift/saturate at AW+1 bits.
  always_comb begin : lane_math
    logic signed [AW-1:0] ext;
    logic signed [AW:0]   rsh;
    logic [OW-1:0]        lane;
    word = '0;
    for (int unsigned i = 0; i < NRES; i++) begin
      ext    = {{(AW - RW){res[i*RW + RW - 1]}}, res[i*RW +: RW]};
      sum[i] = acc_q[i] + ext;
      rsh    = ($signed({sum[i][AW-1], sum[i]}) + rnd) >>> shift_q;
      if (rsh > SAT_MAX)      lane = SAT_MAX[OW-1:0];
      else if (rsh < SAT_MIN) lane = SAT_MIN[OW-1:0];
      else                    lane = rsh[OW-1:0];
`ifdef PSUM_COLLECTOR_RELU_EN
      if (lane[OW-1]) lane = '0;
`endif
      word[i*OW +: OW] = lane;
    end
  end

  always_comb begin
    pop        = (cnt_q != 2'd0) && out_ready;
    accept     = res_valid && (cnt_q != 2'd2) && !cfg_load;
    final_beat = (pass_q == npass_q);
    push       = accept && final_beat;

    npass_d = npass_q;
    shift_d = shift_q;
    pass_d  = pass_q;
    acc_d   = acc_q;
    fifo_d  = fifo_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q | (res_valid && (cnt_q == 2'd2) && !cfg_load);

    if (cfg_load) begin
      npass_d = cfg_npass;
      shift_d = cfg_shift;
      pass_d  = '0;
      for (int unsigned i = 0; i < NRES; i++) acc_d[i] = '0;
    end else if (accept) begin
      if (final_beat) begin
        pass_d = '0;
        for (int unsigned i = 0; i < NRES; i++) acc_d[i] = '0;
      end else begin
        pass_d = pass_q + 4'd1;
        for (int unsigned i = 0; i < NRES; i++) acc_d[i] = sum[i];
      end
    end

    // Slot 0 is always the head; a pop shifts slot 1 forward, and a push lands
    // in the first free slot after that shift.
    if (pop) fifo_d[0] = fifo_q[1];
    if (push) begin
      if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) fifo_d[0] = word;
      else                                              fifo_d[1] = word;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      npass_q <= '0;
      shift_q <= '0;
      pass_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned i = 0; i < NRES; i++) acc_q[i] <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      npass_q <= npass_d;
      shift_q <= shift_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      acc_q   <= acc_d;
      fifo_q  <= fifo_d;
    end
  end

  assign stall     = (cnt_q == 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = fifo_q[0];
  assign ovf_err   = ovf_q;
  assign pass_idx  = pass_q;

endmodule

// File: tb/tb_psum_collector.sv
// Testbench for psum_collector: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference model.
module tb_psum_collector;

  localparam int NRES = 4;
  localparam int RW   = 20;
  localparam int AW   = 28;
  localparam int OW   = 16;
  localparam int SHW  = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cfg_load = 1'b0;
  logic [3:0]           cfg_npass = '0;
  logic [SHW-1:0]       cfg_shift = '0;
  logic                 res_valid = 1'b0;
  logic [NRES*RW-1:0]   res = '0;
  logic                 stall;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [NRES*OW-1:0]   out_data;
  logic                 ovf_err;
  logic [3:0]           pass_idx;

  psum_collector #(.NRES(NRES), .RW(RW), .AW(AW), .OW(OW), .SHW(SHW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_load  (cfg_load),
    .cfg_npass (cfg_npass),
    .cfg_shift (cfg_shift),
    .res_valid (res_valid),
    .res       (res),
    .stall     (stall),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf_err   (ovf_err),
    .pass_idx  (pass_idx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  longint             m_acc [NRES];
  int                 m_pass;
  int                 m_npass;
  int                 m_shift;
  bit                 m_ovf;
  logic [NRES*OW-1:0] m_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] lane_out(input longint s, input int sh);
    longint r;
    r = s;
    if (sh > 0) r = r + (longint'(1) << (sh - 1));
    r = r >>> sh;
    if (r > 2**(OW-1) - 1)     r = 2**(OW-1) - 1;
    else if (r < -(2**(OW-1))) r = -(2**(OW-1));
`ifdef PSUM_COLLECTOR_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[OW-1:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NRES; i++) m_acc[i] = 0;
    m_pass = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    check("stall",     64'(stall),     64'(m_q.size() == 2));
    check("ovf_err",   64'(ovf_err),   64'(m_ovf));
    check("pass_idx",  64'(pass_idx),  64'(m_pass));
    if (m_q.size() != 0) check("out_data", 64'(out_data), 64'(m_q[0]));
  endtask

  // Called at a falling edge: check outputs, drive one cycle, advance model.
  task automatic step(input bit ld, input bit v, input int l0, input int l1,
                      input int l2, input int l3, input bit rdy);
    int l [NRES];
    bit full;
    logic [NRES*OW-1:0] w;
    l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
    check_outputs();
    cfg_load  = ld;
    res_valid = v;
    for (int i = 0; i < NRES; i++) res[i*RW +: RW] = l[i][RW-1:0];
    out_ready = rdy;

    full = (m_q.size() == 2);
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (ld) begin
      m_npass = int'(cfg_npass);
      m_shift = int'(cfg_shift);
      model_clear();
    end else if (v && full) begin
      m_ovf = 1'b1;
    end else if (v) begin
      for (int i = 0; i < NRES; i++) m_acc[i] += l[i];
      if (m_pass == m_npass) begin
        for (int i = 0; i < NRES; i++) w[i*OW +: OW] = lane_out(m_acc[i], m_shift);
        m_q.push_back(w);
        model_clear();
      end else begin
        m_pass++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a falling edge: pulse reset asynchronously mid-cycle.
  task automatic do_reset();
    #2;
    rst       = 1'b1;
    cfg_load  = 1'b0;
    res_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    m_q.delete();
    m_ovf   = 1'b0;
    m_npass = 0;
    m_shift = 0;
    model_clear();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_stall",     64'(stall),     64'(0));
    check("rst_out_data",  64'(out_data),  64'(0));
    check("rst_ovf_err",   64'(ovf_err),   64'(0));
    check("rst_pass_idx",  64'(pass_idx),  64'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int rnd_lane();
    return int'($urandom_range(0, 1048575)) - 524288;
  endfunction

  initial begin
    @(negedge clk);
    do_reset();

    // Single pass, no shift
    cfg_npass = 4'd0; cfg_shift = '0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, -3, 0, 100, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Three passes, shift 2, with a beat discarded by the load
    cfg_npass = 4'd2; cfg_shift = SHW'(2);
    step(1, 1, 7, 7, 7, 7, 0);
    step(0, 1, 3, -4, 1, 0, 0);
    step(0, 1, 4, -3, 1, 0, 0);
    step(0, 1, 3, -3, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Saturation
    cfg_npass = 4'd0; cfg_shift = '0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 40000, -40000, 32767, -32768, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Backpressure: two words fill the FIFO, the third beat is dropped
    step(0, 1, 1, 2, 3, 4, 0);
    step(0, 1, 5, 6, 7, 8, 0);
    step(0, 1, 9, 9, 9, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Back-to-back single-pass words with continuous pops
    for (int k = 0; k < 8; k++) step(0, 1, k, -k, 100 * k, -1000 * k, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Reset in the middle of a 4-pass word, then a fresh 4-pass word
    cfg_npass = 4'd3; cfg_shift = '0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1000, 2000, 3000, 4000, 0);
    step(0, 1, 1000, 2000, 3000, 4000, 0);
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 10, -20, 30, -40, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      bit ld;
      ld = ($urandom_range(0, 24) == 0);
      if (ld) begin
        cfg_npass = 4'($urandom_range(0, 3));
        cfg_shift = SHW'($urandom_range(0, 12));
      end
      step(ld, $urandom_range(0, 3) != 0, rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane(),
           $urandom_range(0, 2) != 0);
    end
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 1);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
# psum_collector

Receiving end of the adder-tree result interface: it consumes `res_valid`/`res` beats from the adder tree and accumulates them across input-channel passes. It applies a rounding right-shift and signed saturation to each lane and buffers finished output words in a 2-entry FIFO. A valid/ready handshake presents those words to the output feature-map writer. It sits between the adder tree and the output buffer, and throttles the tree through `stall`.

## Interface
- `NRES`, 4, number of result lanes per `res` beat
- `RW`, 20, signed width of one adder-tree lane
- `AW`, 28, signed accumulator width per lane
- `OW`, 16, signed output lane width after shift/saturate
- `SHW`, 5, width of the shift-amount field

- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cfg_load`  in  1  latch `cfg_npass`/`cfg_shift`; clears accumulators and pass counter
- `cfg_npass`  in  4  passes per output word minus 1 (0 → 1 pass, 15 → 16 passes)
- `cfg_shift`  in  SHW  arithmetic right-shift applied before saturation
- `res_valid`  in  1  adder-tree beat valid
- `res`  in  NRES*RW  lane i at bits [i*RW +: RW], two's complement
- `stall`  out  1  upstream must not assert `res_valid` while high
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  downstream accepts head
- `out_data`  out  NRES*OW  lane i at [i*OW +: OW]
- `ovf_err`  out  1  sticky: a beat arrived while full and was dropped
- `pass_idx`  out  4  current pass count, for debug

## Operation
- Registers: `npass_q`, `shift_q`, `pass_q` (4b), `acc[NRES]` (AW), FIFO of 2 × NRES*OW, and `cnt` (0..2).
- **ACC state** (`pass_q` < `npass_q`): an accepted beat sets `acc[i] += sext(res[i])` and increments `pass_q`.
- **FINAL beat** (`pass_q` == `npass_q`):
  - Compute `s = acc[i] + sext(res[i])`.
  - Apply `r = (s + (shift_q ? 1<<(shift_q-1) : 0)) >>> shift_q`, evaluated at AW+1 bits.
  - Saturate `r` to [-2^(OW-1), 2^(OW-1)-1].
  - Push the word into the FIFO, clear `acc` to 0 and `pass_q` to 0.
- A beat is accepted iff `res_valid && cnt != 2`.
- `res_valid && cnt == 2`: the beat is dropped, `ovf_err` is set, and accumulator state is unchanged.
- `stall = (cnt == 2)`.
- Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle at `cnt == 1`: `cnt` stays 1 and the new word is at the head next cycle.
  - Push and pop at `cnt == 2` cannot occur, because the push is blocked.
- `cfg_load`:
  - Takes priority over a same-cycle beat (the beat is discarded, and this is not an error).
  - Does not touch the FIFO or `ovf_err`.
- `ovf_err` clears only on `rst`.
- Accumulator overflow beyond AW wraps; sizing AW is the integrator's responsibility.

## Timing
- Reset values:
  - `stall` = 0, `out_valid` = 0, `out_data` = 0, `ovf_err` = 0, `pass_idx` = 0.
  - `npass_q` = 0, `shift_q` = 0, `acc` = 0, `cnt` = 0.
- Latency: a final beat accepted at edge N gives `out_valid` high after edge N, visible in cycle N+1, when the FIFO was empty.
- `out_data` is registered (FIFO head) and stable while `out_valid && !out_ready`.
- `stall` is registered state (derived from `cnt`). It rises in the cycle after the second unpopped push.
- Reset asserted mid-accumulation drops the partial sums and FIFO contents immediately.
- Throughput: one beat per cycle while `out_ready` stays high.

## Configuration
- Macro: `PSUM_COLLECTOR_RELU_EN`.
- Defined: negative saturated lanes are forced to 0 before the FIFO push, applied after rounding and saturation.
- Undefined: lanes pass signed, unchanged.

## Test plan
- Single-pass word, `cfg_npass`=0, `cfg_shift`=0, `res` lanes {5,-3,0,100} → `out_valid` next cycle with lanes {5,-3,0,100}; `pass_idx` stays 0.
- Three passes (`cfg_npass`=2, `cfg_shift`=2) of lane0 = 3, 4, 3 (sum 10) → lane0 = 3, since (10+2)>>>2 = 3. Lane0 = -10 → (-10+2)>>>2 = -2. With RELU_EN the -2 becomes 0.
- Saturation with `cfg_shift`=0, OW=16: sum 40000 → 32767; sum -40000 → -32768.
- Backpressure: hold `out_ready`=0 and send 2 final beats → `stall`=1 after the second. A 3rd beat is dropped, `ovf_err`=1, and the FIFO keeps words 1 and 2 in order.
- Simultaneous push/pop at `cnt`=1 with `out_ready`=1 every cycle, 8 single-pass beats back-to-back → 8 words out in order, `stall` never rises.
- `rst` after 2 of 4 passes → all outputs return to reset values. A fresh 4-pass sequence yields only the new sum.
